fir_output_buffer: RTL and testbench

Sink-side buffer for the FIR filter output stream. It consumes 16-bit signed filtered samples with a valid strobe, packs sample pairs into 32-bit words and stores them in a synchronous FIFO. The FIFO is drained by the HPS-facing CSR read path with a read strobe, and status and sticky error flags are exported for the CSR block. It sits between the FIR filter output and the register interface.

---
 rtl/fir_output_buffer_if.sv | 29 ++
 rtl/fir_output_buffer.sv | 195 +++++++++++++++++++
 tb/tb_fir_output_buffer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_output_buffer_if.sv
// Bundle of the FIR output buffer signals. The master side is the
// sample source plus the CSR read path. The slave side is the buffer itself.
interface fir_output_buffer_if #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              enable;
  logic              clear;
  logic              sample_valid;
  logic [15:0]       sample;
  logic              rd_req;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   level;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output enable, clear, sample_valid, sample, rd_req,
    input  rd_data, rd_valid, level, empty, full, overflow, underflow
  );

  modport slave (
    input  enable, clear, sample_valid, sample, rd_req,
    output rd_data, rd_valid, level, empty, full, overflow, underflow
  );
endinterface

// File: rtl/fir_output_buffer.sv
// FIR output buffer. It packs pairs of 16-bit samples into 32-bit words,
// with the older sample in the low half, and stores them in a synchronous
// FIFO that the CSR read path drains. Status and sticky error flags are
// registered.
module fir_output_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  fir_output_buffer_if.slave bus
);
  localparam int LVL_W = ADDR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } pack_state_t;

  pack_state_t       state_r;
  pack_state_t       state_nxt_s;
  logic [15:0]       held_r;
  logic              latch_low_s;
  logic              wr_req_s;
  logic [31:0]       wr_word_s;

  logic [31:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [LVL_W-1:0]  level_nxt_s;
  logic              empty_r;
  logic              full_r;
  logic              overflow_r;
  logic              underflow_r;
  logic              rd_valid_r;
  logic [31:0]       rd_data_r;

  logic              wr_accept_s;
  logic              rd_accept_s;
  logic              ovf_event_s;
  logic              unf_event_s;

  // Pack FSM next state: clear and disable force LOW, and only valid samples advance it.
  always_comb begin
    state_nxt_s = state_r;
    latch_low_s = 1'b0;
    wr_req_s    = 1'b0;
    wr_word_s   = {bus.sample, held_r};
    if (bus.clear) begin
      state_nxt_s = ST_LOW;
    end else if (!bus.enable) begin
      state_nxt_s = ST_LOW;
    end else if (bus.sample_valid) begin
      case (state_r)
        ST_LOW: begin
          latch_low_s = 1'b1;
          state_nxt_s = ST_HIGH;
        end
        ST_HIGH: begin
          wr_req_s    = 1'b1;
          state_nxt_s = ST_LOW;
        end
        default: begin
          state_nxt_s = ST_LOW;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Accept reads and writes. A read frees a slot, so a write while full still fits in that cycle.
  always_comb begin
    rd_accept_s = 1'b0;
    wr_accept_s = 1'b0;
    ovf_event_s = 1'b0;
    unf_event_s = 1'b0;
    if (bus.clear) begin
      rd_accept_s = 1'b0;
      wr_accept_s = 1'b0;
    end else begin
      if (bus.rd_req) begin
        if (!empty_r) begin
          rd_accept_s = 1'b1;
        end else begin
          unf_event_s = 1'b1;
        end
      end else begin
        rd_accept_s = 1'b0;
      end
      if (wr_req_s) begin
        if (!full_r || rd_accept_s) begin
          wr_accept_s = 1'b1;
        end else begin
          ovf_event_s = 1'b1;
        end
      end else begin
        wr_accept_s = 1'b0;
      end
    end
  end

  // Next fill level: a write alone adds one, a read alone removes one, and clear empties the FIFO.
  always_comb begin
    level_nxt_s = level_r;
    if (bus.clear) begin
      level_nxt_s = {LVL_W{1'b0}};
    end else begin
      case ({wr_accept_s, rd_accept_s})
        2'b10:   level_nxt_s = level_r + LVL_W'(1);
        2'b01:   level_nxt_s = level_r - LVL_W'(1);
        default: level_nxt_s = level_r;
      endcase
    end
  end

  // Pack state register and held low half-word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_LOW;
      held_r  <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      if (bus.clear) begin
        held_r <= 16'h0000;
      end else if (latch_low_s) begin
        held_r <= bus.sample;
      end
    end
  end

  // FIFO storage. It has no reset because stale contents are never read.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r] <= wr_word_s;
    end
  end

  // Pointers, level, status and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      level_r     <= {LVL_W{1'b0}};
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      level_r     <= {LVL_W{1'b0}};
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_accept_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (rd_accept_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
      level_r     <= level_nxt_s;
      empty_r     <= (level_nxt_s == {LVL_W{1'b0}});
      full_r      <= (level_nxt_s == LVL_FULL);
      overflow_r  <= overflow_r | ovf_event_s;
      underflow_r <= underflow_r | unf_event_s;
    end
  end

  // Registered read port. rd_data holds its value when nothing is read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= 32'h0000_0000;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_accept_s;
      if (rd_accept_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  assign bus.rd_data   = rd_data_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.level     = level_r;
  assign bus.empty     = empty_r;
  assign bus.full      = full_r;
  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;

endmodule

// File: tb/tb_fir_output_buffer.sv
// Directed bench for fir_output_buffer. It runs with a small FIFO so that
// the full and wrap cases stay short.
module tb_fir_output_buffer;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;

  fir_output_buffer_if #(.DEPTH(DEPTH)) bus_if ();

  fir_output_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [15:0] held_m   = 16'h0000;
  bit          pend_m   = 1'b0;
  int          lvl_m    = 0;
  logic [31:0] last_m;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bench model of the pairing: the older sample goes into the low half.
  task automatic model_sample(input logic [15:0] s);
    if (pend_m) begin
      exp_q.push_back({s, held_m});
      pend_m = 1'b0;
    end else begin
      held_m = s;
      pend_m = 1'b1;
    end
  endtask

  task automatic send(input logic [15:0] s);
    bus_if.sample_valid = 1'b1;
    bus_if.sample       = s;
    tick();
    bus_if.sample_valid = 1'b0;
    model_sample(s);
  endtask

  task automatic read_chk(input string tag);
    bus_if.rd_req = 1'b1;
    tick();
    bus_if.rd_req = 1'b0;
    chk_eq({tag, "_valid"}, 32'(bus_if.rd_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk_eq({tag, "_model_empty"}, 32'd0, 32'd1);
    end else begin
      last_m = exp_q.pop_front();
      chk_eq({tag, "_data"}, bus_if.rd_data, last_m);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    pend_m = 1'b0;
    held_m = 16'h0000;
  endtask

  initial begin
    int cyc;
    int written;
    bit sv;
    bit rd;
    bit wr;
    logic [15:0] val;

    rst_n               = 1'b0;
    bus_if.enable       = 1'b0;
    bus_if.clear        = 1'b0;
    bus_if.sample_valid = 1'b0;
    bus_if.sample       = 16'h0000;
    bus_if.rd_req       = 1'b0;
    tick();
    tick();
    // reset state
    chk_eq("rst_rd_data", bus_if.rd_data, 32'h0);
    chk_eq("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
    chk_eq("rst_level", 32'(bus_if.level), 32'd0);
    chk_eq("rst_empty", 32'(bus_if.empty), 32'd1);
    chk_eq("rst_full", 32'(bus_if.full), 32'd0);
    chk_eq("rst_overflow", 32'(bus_if.overflow), 32'd0);
    chk_eq("rst_underflow", 32'(bus_if.underflow), 32'd0);
    rst_n = 1'b1;
    tick();
    bus_if.enable = 1'b1;
    tick();

    // basic pair with a gap of five idle cycles
    send(16'h1234);
    repeat (5) tick();
    send(16'hABCD);
    chk_eq("pair_level", 32'(bus_if.level), 32'd1);
    chk_eq("pair_empty", 32'(bus_if.empty), 32'd0);
    read_chk("pair_read");
    chk_eq("pair_word", bus_if.rd_data, 32'hABCD_1234);
    chk_eq("pair_level_after", 32'(bus_if.level), 32'd0);
    chk_eq("pair_empty_after", 32'(bus_if.empty), 32'd1);
    tick();
    chk_eq("pair_valid_drop", 32'(bus_if.rd_valid), 32'd0);

    // fill past full: DEPTH+1 words, and the last one is dropped
    reset_model();
    for (int i = 0; i < 2 * DEPTH; i++) send(16'(i));
    chk_eq("fill_full_noovf", 32'(bus_if.overflow), 32'd0);
    send(16'(2 * DEPTH));
    send(16'(2 * DEPTH + 1));
    void'(exp_q.pop_back());
    chk_eq("fill_full", 32'(bus_if.full), 32'd1);
    chk_eq("fill_level", 32'(bus_if.level), 32'(DEPTH));
    chk_eq("fill_overflow", 32'(bus_if.overflow), 32'd1);
    read_chk("fill_first");
    chk_eq("fill_first_word", bus_if.rd_data, 32'h0001_0000);
    for (int i = 1; i < DEPTH; i++) read_chk("fill_read");
    chk_eq("fill_last_word", bus_if.rd_data, {16'(2 * DEPTH - 1), 16'(2 * DEPTH - 2)});
    chk_eq("fill_drained", 32'(bus_if.empty), 32'd1);

    // read while empty
    bus_if.rd_req = 1'b1;
    tick();
    bus_if.rd_req = 1'b0;
    chk_eq("unf_valid", 32'(bus_if.rd_valid), 32'd0);
    chk_eq("unf_data_hold", bus_if.rd_data, {16'(2 * DEPTH - 1), 16'(2 * DEPTH - 2)});
    chk_eq("unf_flag", 32'(bus_if.underflow), 32'd1);
    bus_if.clear = 1'b1;
    tick();
    bus_if.clear = 1'b0;
    chk_eq("clr_underflow", 32'(bus_if.underflow), 32'd0);
    chk_eq("clr_overflow", 32'(bus_if.overflow), 32'd0);

    // full, then a final-sample write together with a read
    reset_model();
    for (int i = 0; i < 2 * DEPTH + 1; i++) send(16'(16'h0100 + i));
    chk_eq("sim_full", 32'(bus_if.full), 32'd1);
    bus_if.sample_valid = 1'b1;
    bus_if.sample       = 16'(16'h0100 + 2 * DEPTH + 1);
    bus_if.rd_req       = 1'b1;
    tick();
    bus_if.sample_valid = 1'b0;
    bus_if.rd_req       = 1'b0;
    chk_eq("sim_valid", 32'(bus_if.rd_valid), 32'd1);
    last_m = exp_q.pop_front();
    chk_eq("sim_data", bus_if.rd_data, last_m);
    model_sample(16'(16'h0100 + 2 * DEPTH + 1));
    chk_eq("sim_level", 32'(bus_if.level), 32'(DEPTH));
    chk_eq("sim_full_still", 32'(bus_if.full), 32'd1);
    chk_eq("sim_overflow", 32'(bus_if.overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) read_chk("sim_drain");
    chk_eq("sim_last", bus_if.rd_data, {16'(16'h0100 + 2 * DEPTH + 1), 16'(16'h0100 + 2 * DEPTH)});
    chk_eq("sim_empty", 32'(bus_if.empty), 32'd1);

    // clear discards a held half-word
    reset_model();
    send(16'h0001);
    bus_if.clear = 1'b1;
    tick();
    bus_if.clear = 1'b0;
    reset_model();
    send(16'h0005);
    send(16'h0006);
    chk_eq("clrpair_level", 32'(bus_if.level), 32'd1);
    read_chk("clrpair_read");
    chk_eq("clrpair_word", bus_if.rd_data, 32'h0006_0005);

    // clear has priority over a same-cycle read and keeps rd_data
    reset_model();
    send(16'h0011);
    send(16'h0022);
    bus_if.clear  = 1'b1;
    bus_if.rd_req = 1'b1;
    tick();
    bus_if.clear  = 1'b0;
    bus_if.rd_req = 1'b0;
    chk_eq("clrrd_valid", 32'(bus_if.rd_valid), 32'd0);
    chk_eq("clrrd_level", 32'(bus_if.level), 32'd0);
    chk_eq("clrrd_data", bus_if.rd_data, 32'h0006_0005);
    chk_eq("clrrd_underflow", 32'(bus_if.underflow), 32'd0);
    reset_model();

    // asynchronous reset in the middle of operation
    send(16'h0033);
    send(16'h0044);
    read_chk("arst_pre_read");
    send(16'h0055);
    send(16'h0066);
    rst_n = 1'b0;
    #1;
    chk_eq("arst_rd_data", bus_if.rd_data, 32'h0);
    chk_eq("arst_level", 32'(bus_if.level), 32'd0);
    chk_eq("arst_empty", 32'(bus_if.empty), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    reset_model();

    // dropping enable discards a held half-word and ignores samples
    send(16'h0001);
    bus_if.enable       = 1'b0;
    bus_if.sample_valid = 1'b1;
    bus_if.sample       = 16'h7777;
    tick();
    bus_if.sample_valid = 1'b0;
    bus_if.enable       = 1'b1;
    reset_model();
    send(16'h0005);
    send(16'h0006);
    chk_eq("enpair_level", 32'(bus_if.level), 32'd1);
    read_chk("enpair_read");
    chk_eq("enpair_word", bus_if.rd_data, 32'h0006_0005);

    // pointer wrap with random interleaved reads, never overflowing
    reset_model();
    lvl_m   = 0;
    written = 0;
    cyc     = 0;
    val     = 16'h4000;
    while ((written < 3 * DEPTH || lvl_m > 0) && cyc < 3000) begin
      sv = (written < 3 * DEPTH) && ($urandom_range(0, 1) == 1);
      rd = (lvl_m > 0) && ($urandom_range(0, 2) != 0);
      wr = sv && pend_m;
      if (wr && lvl_m == DEPTH && !rd) begin
        sv = 1'b0;
        wr = 1'b0;
      end
      bus_if.sample_valid = sv;
      bus_if.sample       = val;
      bus_if.rd_req       = rd;
      tick();
      bus_if.sample_valid = 1'b0;
      bus_if.rd_req       = 1'b0;
      if (rd) begin
        last_m = exp_q.pop_front();
        chk_eq("wrap_valid", 32'(bus_if.rd_valid), 32'd1);
        chk_eq("wrap_data", bus_if.rd_data, last_m);
      end else begin
        chk_eq("wrap_novalid", 32'(bus_if.rd_valid), 32'd0);
      end
      if (sv) begin
        model_sample(val);
        val = val + 16'h0001;
      end
      if (wr) written++;
      lvl_m = lvl_m + (wr ? 1 : 0) - (rd ? 1 : 0);
      chk_eq("wrap_level", 32'(bus_if.level), 32'(lvl_m));
      cyc++;
    end
    chk_eq("wrap_in_budget", 32'(cyc < 3000), 32'd1);
    chk_eq("wrap_overflow", 32'(bus_if.overflow), 32'd0);
    chk_eq("wrap_underflow", 32'(bus_if.underflow), 32'd0);
    chk_eq("wrap_empty", 32'(bus_if.empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
